// File: rtl/xbar_port_arbiter_if.sv
// Request/grant bundle between the input staging, the port arbiter and the crossbar datapath.
interface xbar_port_arbiter_if #(
  parameter int PORTS = 4
);
  localparam int DEST_W = $clog2(PORTS);

  logic [PORTS-1:0]        req_valid;
  logic [PORTS*DEST_W-1:0] req_dest;
  logic                    beat_en;
  logic [PORTS-1:0]        grant;
  logic [PORTS-1:0]        out_busy;
  logic [PORTS*DEST_W-1:0] out_src;
  logic [PORTS-1:0]        done;

  modport master (
    output req_valid, req_dest, beat_en,
    input  grant, out_busy, out_src, done
  );

  modport slave (
    input  req_valid, req_dest, beat_en,
    output grant, out_busy, out_src, done
  );
endinterface

// File: rtl/xbar_port_arbiter.sv
// Per-output round-robin arbiter: each output is held by one input for a whole packet
// and released after its last beat (or immediately if the requester withdraws).
module xbar_port_arbiter #(
  parameter int PORTS = 4,
  parameter int BEATS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  xbar_port_arbiter_if.slave     bus
);
  localparam int DEST_W = $clog2(PORTS);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q [PORTS];
  logic [CNT_W-1:0]        cnt_q   [PORTS];
  logic [DEST_W-1:0]       ptr_q   [PORTS];
  logic [DEST_W-1:0]       src_q   [PORTS];
  logic [PORTS-1:0]        grant_q;
  logic [PORTS-1:0]        busy_q;
  logic [PORTS-1:0]        done_q;

  logic [DEST_W-1:0]       dest_arr   [PORTS];
  logic [DEST_W-1:0]       pick       [PORTS];
  logic [PORTS-1:0]        pick_valid;

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    assign dest_arr[gi] = bus.req_dest[gi*DEST_W +: DEST_W];
    assign bus.out_src[gi*DEST_W +: DEST_W] = src_q[gi];

    // A granted requester must keep its destination until it is released.
    a_dest_stable: assert property (@(posedge clk) disable iff (rst)
      (grant_q[gi] && bus.req_valid[gi]) |-> $stable(dest_arr[gi]));
  end

  assign bus.grant    = grant_q;
  assign bus.out_busy = busy_q;
  assign bus.done     = done_q;

  a_grant_busy_match: assert property (@(posedge clk) disable iff (rst)
    $countones(grant_q) == $countones(busy_q));

  // Round-robin scan starting just after the last owner; already-granted inputs are skipped.
  always_comb begin
    pick_valid = '0;
    for (int o = 0; o < PORTS; o++) begin
      pick[o] = '0;
      for (int k = 1; k <= PORTS; k++) begin
        int                tmp;
        logic [DEST_W-1:0] idx;
        tmp = (int'(ptr_q[o]) + k) % PORTS;
        idx = DEST_W'(tmp);
        if (!pick_valid[o] && bus.req_valid[idx] && !grant_q[idx] &&
            dest_arr[idx] == DEST_W'(o)) begin
          pick_valid[o] = 1'b1;
          pick[o]       = idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= IDLE;
        cnt_q[o]   <= '0;
        ptr_q[o]   <= DEST_W'(PORTS - 1);
        src_q[o]   <= '0;
      end
    end else begin
      done_q <= '0;
      for (int o = 0; o < PORTS; o++) begin
        case (state_q[o])
          IDLE: begin
            if (pick_valid[o]) begin
              state_q[o]        <= BUSY;
              src_q[o]          <= pick[o];
              busy_q[o]         <= 1'b1;
              grant_q[pick[o]]  <= 1'b1;
              cnt_q[o]          <= '0;
            end
          end
          BUSY: begin
            // A withdrawn request frees the output without signalling completion.
            if (!bus.req_valid[src_q[o]]) begin
              state_q[o]        <= IDLE;
              busy_q[o]         <= 1'b0;
              grant_q[src_q[o]] <= 1'b0;
              ptr_q[o]          <= src_q[o];
              cnt_q[o]          <= '0;
            end else if (bus.beat_en) begin
              if (cnt_q[o] == CNT_W'(BEATS - 1)) begin
                state_q[o]        <= IDLE;
                busy_q[o]         <= 1'b0;
                grant_q[src_q[o]] <= 1'b0;
                done_q[src_q[o]]  <= 1'b1;
                ptr_q[o]          <= src_q[o];
                cnt_q[o]          <= '0;
              end else begin
                cnt_q[o] <= cnt_q[o] + CNT_W'(1);
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_xbar_port_arbiter.sv
// Directed bench for xbar_port_arbiter: single, contention, parallel, abort, reset, streaming.
module tb_xbar_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] t2_grant [10];
  logic [3:0] t2_done  [10];
  logic [1:0] t2_src   [10];

  xbar_port_arbiter_if #(.PORTS(4)) bus ();

  xbar_port_arbiter #(.PORTS(4), .BEATS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rv, input logic [7:0] dest, input logic be);
    bus.req_valid = rv;
    bus.req_dest  = dest;
    bus.beat_en   = be;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    t2_grant = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
                 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    t2_done  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000,
                 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    t2_src   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0};

    // Reset state
    rst = 1'b1;
    applyStimulus(4'b0000, 8'h00, 1'b0);
    tick(2);
    checkOutput("rst_grant", 32'(bus.grant), 32'h0);
    checkOutput("rst_busy",  32'(bus.out_busy), 32'h0);
    checkOutput("rst_src",   32'(bus.out_src), 32'h0);
    checkOutput("rst_done",  32'(bus.done), 32'h0);

    // T1: in2 -> out1 with a beat every 10 cycles
    $display("[TB] T1 single request");
    rst = 1'b0;
    applyStimulus(4'b0100, 8'h10, 1'b0);
    tick(1);
    checkOutput("t1_grant", 32'(bus.grant), 32'h4);
    checkOutput("t1_busy",  32'(bus.out_busy), 32'h2);
    checkOutput("t1_src",   32'(bus.out_src[3:2]), 32'd2);
    tick(9);
    bus.beat_en = 1'b1;
    tick(1);
    bus.beat_en = 1'b0;
    checkOutput("t1_mid_grant", 32'(bus.grant), 32'h4);
    checkOutput("t1_mid_done",  32'(bus.done), 32'h0);
    tick(9);
    bus.beat_en = 1'b1;
    tick(1);
    checkOutput("t1_end_grant", 32'(bus.grant), 32'h0);
    checkOutput("t1_end_done",  32'(bus.done), 32'h4);
    checkOutput("t1_end_busy",  32'(bus.out_busy), 32'h0);
    applyStimulus(4'b0000, 8'h10, 1'b0);
    tick(1);
    checkOutput("t1_done_pulse", 32'(bus.done), 32'h0);

    // T2: in0, in1, in3 -> out2 held from reset, beat_en high
    $display("[TB] T2 contention");
    rst = 1'b1;
    applyStimulus(4'b1011, 8'hAA, 1'b1);
    tick(1);
    checkOutput("t2_rst_grant", 32'(bus.grant), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checkOutput($sformatf("t2_grant_%0d", k), 32'(bus.grant), 32'(t2_grant[k]));
      checkOutput($sformatf("t2_done_%0d", k),  32'(bus.done),  32'(t2_done[k]));
      if (t2_grant[k] != 4'b0000)
        checkOutput($sformatf("t2_src_%0d", k), 32'(bus.out_src[5:4]), 32'(t2_src[k]));
    end
    applyStimulus(4'b0000, 8'hAA, 1'b0);
    tick(1);
    checkOutput("t2_abort_grant", 32'(bus.grant), 32'h0);
    checkOutput("t2_abort_busy",  32'(bus.out_busy), 32'h0);
    checkOutput("t2_abort_done",  32'(bus.done), 32'h0);

    // T3: four disjoint requests on the same cycle
    $display("[TB] T3 parallel");
    applyStimulus(4'b1111, 8'h1B, 1'b0);
    tick(1);
    checkOutput("t3_grant", 32'(bus.grant), 32'hF);
    checkOutput("t3_busy",  32'(bus.out_busy), 32'hF);
    checkOutput("t3_src",   32'(bus.out_src), 32'h1B);
    bus.beat_en = 1'b1;
    tick(1);
    checkOutput("t3_mid_grant", 32'(bus.grant), 32'hF);
    checkOutput("t3_mid_done",  32'(bus.done), 32'h0);
    tick(1);
    checkOutput("t3_end_grant", 32'(bus.grant), 32'h0);
    checkOutput("t3_end_done",  32'(bus.done), 32'hF);
    applyStimulus(4'b0000, 8'h1B, 1'b0);
    tick(1);
    checkOutput("t3_done_pulse", 32'(bus.done), 32'h0);

    // T4: in1 aborts after one beat, in2 queued for the same output
    $display("[TB] T4 abort");
    applyStimulus(4'b0110, 8'h00, 1'b0);
    tick(1);
    checkOutput("t4_grant1", 32'(bus.grant), 32'h2);
    checkOutput("t4_src1",   32'(bus.out_src[1:0]), 32'd1);
    applyStimulus(4'b0110, 8'h00, 1'b1);
    tick(1);
    checkOutput("t4_beat_grant", 32'(bus.grant), 32'h2);
    applyStimulus(4'b0100, 8'h00, 1'b0);
    tick(1);
    checkOutput("t4_abort_grant", 32'(bus.grant), 32'h0);
    checkOutput("t4_abort_done",  32'(bus.done), 32'h0);
    checkOutput("t4_abort_busy",  32'(bus.out_busy), 32'h0);
    tick(1);
    checkOutput("t4_grant2", 32'(bus.grant), 32'h4);
    checkOutput("t4_src2",   32'(bus.out_src[1:0]), 32'd2);
    checkOutput("t4_no_done", 32'(bus.done), 32'h0);
    bus.beat_en = 1'b1;
    tick(2);
    checkOutput("t4_done2", 32'(bus.done), 32'h4);
    applyStimulus(4'b0000, 8'h00, 1'b0);
    tick(1);

    // T5: reset while out0 is busy restores the priority pointer
    $display("[TB] T5 reset mid-packet");
    applyStimulus(4'b1001, 8'h00, 1'b0);
    tick(1);
    checkOutput("t5_pre_grant", 32'(bus.grant), 32'h8);
    rst = 1'b1;
    tick(1);
    checkOutput("t5_rst_grant", 32'(bus.grant), 32'h0);
    checkOutput("t5_rst_busy",  32'(bus.out_busy), 32'h0);
    checkOutput("t5_rst_src",   32'(bus.out_src), 32'h0);
    checkOutput("t5_rst_done",  32'(bus.done), 32'h0);
    rst = 1'b0;
    tick(1);
    checkOutput("t5_post_grant", 32'(bus.grant), 32'h1);
    checkOutput("t5_post_src",   32'(bus.out_src[1:0]), 32'd0);
    applyStimulus(4'b0000, 8'h00, 1'b0);
    tick(1);
    checkOutput("t5_release", 32'(bus.grant), 32'h0);

    // T6: in3 -> out3 streaming with beat_en tied high
    $display("[TB] T6 streaming");
    applyStimulus(4'b1000, 8'hC0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      tick(1);
      checkOutput($sformatf("t6_grant_%0d", k), 32'(bus.grant),
                  (k % 3 == 2) ? 32'h0 : 32'h8);
      checkOutput($sformatf("t6_busy_%0d", k), 32'(bus.out_busy),
                  (k % 3 == 2) ? 32'h0 : 32'h8);
      checkOutput($sformatf("t6_done_%0d", k), 32'(bus.done),
                  (k % 3 == 2) ? 32'h8 : 32'h0);
    end
    applyStimulus(4'b0000, 8'hC0, 1'b0);
    tick(2);
    checkOutput("t6_idle", 32'(bus.grant), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
